// File: rtl/sequenciador_ebulidor_pkg.sv
// Shared definitions for the coffee-machine sequencers: state encodings,
// default limits and a small state-classification helper.
package sequenciador_ebulidor_pkg;

  // Timeout pulses allowed in a heat cycle before it is declared failed.
  localparam int unsigned MAX_SEGUNDOS_DEF = 240;

  // Width of the elapsed-seconds counter.
  localparam int unsigned W_SEG_DEF = 8;

  // Heat-cycle sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ZERA    = 3'd1,
    ST_LIGA    = 3'd2,
    ST_ESPERA  = 3'd3,
    ST_CONCLUI = 3'd4,
    ST_FALHA   = 3'd5
  } estado_e;

  // A state is "busy" while a heat cycle is being driven. IDLE and the two
  // terminal states accept a new request.
  function automatic logic estado_ocupado(input estado_e s);
    return (s == ST_ZERA) || (s == ST_LIGA) || (s == ST_ESPERA);
  endfunction

endpackage

// File: rtl/sequenciador_ebulidor.sv
// Heat-cycle sequencer: clears and starts the heater controller, then waits
// for its done indication while counting one-second ticks. Ends in CONCLUI on
// success, FALHA on timeout, or IDLE on cancel. Every output is a register.
module sequenciador_ebulidor
  import sequenciador_ebulidor_pkg::*;
#(
  parameter int unsigned MAX_SEGUNDOS = MAX_SEGUNDOS_DEF,
  parameter int unsigned W_SEG        = W_SEG_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar,
  input  logic             cancela,
  input  logic             fim_ebulidor,
  input  logic             timeout,
  output logic             liga_ebulidor,
  output logic             zera_ebulidor,
  output logic             ocupado,
  output logic             pronto,
  output logic             erro,
  output logic [W_SEG-1:0] segundos
);

  // Counter value at which the next tick exhausts the allowance.
  localparam logic [W_SEG-1:0] SEG_LIMITE = W_SEG'(MAX_SEGUNDOS - 1);
  // Saturation value of the counter.
  localparam logic [W_SEG-1:0] SEG_SAT    = {W_SEG{1'b1}};

  estado_e          estado_q, estado_d;
  logic [W_SEG-1:0] seg_q, seg_d;
  logic [W_SEG-1:0] seg_inc;
  logic             liga_q, liga_d;
  logic             zera_q, zera_d;
  logic             pronto_q, pronto_d;
  logic             erro_q, erro_d;
  logic             ocupado_q, ocupado_d;

  // Saturating increment of the elapsed-seconds counter.
  always_comb begin
    seg_inc = (seg_q == SEG_SAT) ? seg_q : seg_q + W_SEG'(1);
  end

  // Next state and next registered outputs. Cancel outranks done and tick;
  // done outranks a simultaneous final tick.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    estado_d = estado_q;
    seg_d    = seg_q;
    liga_d   = 1'b0;
    zera_d   = 1'b0;
    pronto_d = 1'b0;
    erro_d   = erro_q;

    unique case (estado_q)
      ST_IDLE, ST_CONCLUI, ST_FALHA: begin
        if (iniciar) begin
          estado_d = ST_ZERA;
          seg_d    = '0;
          erro_d   = 1'b0;
          zera_d   = 1'b1;
        end else if (cancela) begin
          estado_d = ST_IDLE;
          erro_d   = 1'b0;
        end
      end

      ST_ZERA: begin
        if (cancela) begin
          estado_d = ST_IDLE;
          zera_d   = 1'b1;
        end else begin
          estado_d = ST_LIGA;
          liga_d   = 1'b1;
        end
      end

      ST_LIGA: begin
        if (cancela) begin
          estado_d = ST_IDLE;
          zera_d   = 1'b1;
        end else begin
          estado_d = ST_ESPERA;
        end
      end

      ST_ESPERA: begin
        if (cancela) begin
          estado_d = ST_IDLE;
          zera_d   = 1'b1;
        end else begin
          if (timeout) begin
            seg_d = seg_inc;
          end
          if (fim_ebulidor) begin
            estado_d = ST_CONCLUI;
            pronto_d = 1'b1;
          end else if (timeout && (seg_q == SEG_LIMITE)) begin
            estado_d = ST_FALHA;
            zera_d   = 1'b1;
            erro_d   = 1'b1;
          end
        end
      end

      default: begin
        estado_d = ST_IDLE;
      end
    endcase
  end

  // Busy flag follows the state being entered so it lines up with the state.
  always_comb begin
    ocupado_d = estado_ocupado(estado_d);
  end

  // State and output registers; reset abandons any cycle without a clear pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= ST_IDLE;
      seg_q     <= '0;
      liga_q    <= 1'b0;
      zera_q    <= 1'b0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values from before this edge, regardless of statement order.
      estado_q  <= estado_d;
      seg_q     <= seg_d;
      liga_q    <= liga_d;
      zera_q    <= zera_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign liga_ebulidor = liga_q;
  assign zera_ebulidor = zera_q;
  assign pronto        = pronto_q;
  assign erro          = erro_q;
  assign ocupado       = ocupado_q;
  assign segundos      = seg_q;

endmodule

// File: tb/tb_sequenciador_ebulidor.sv
// Bench for sequenciador_ebulidor with MAX_SEGUNDOS=4: directed scenarios with
// literal expectations, then random stimulus, all compared every cycle against
// a cycle-age model of the heat sequence.
module tb_sequenciador_ebulidor;

  localparam int MAX_S = 4;
  localparam int W_S   = 8;
  localparam int SAT_S = (1 << W_S) - 1;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           iniciar = 1'b0;
  logic           cancela = 1'b0;
  logic           fim_ebulidor = 1'b0;
  logic           timeout = 1'b0;
  logic           liga_ebulidor;
  logic           zera_ebulidor;
  logic           ocupado;
  logic           pronto;
  logic           erro;
  logic [W_S-1:0] segundos;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sequenciador_ebulidor #(
    .MAX_SEGUNDOS(MAX_S),
    .W_SEG       (W_S)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .cancela      (cancela),
    .fim_ebulidor (fim_ebulidor),
    .timeout      (timeout),
    .liga_ebulidor(liga_ebulidor),
    .zera_ebulidor(zera_ebulidor),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .erro         (erro),
    .segundos     (segundos)
  );

  always #5 clock = ~clock;

  // Model: a heat cycle is "running" from acceptance until it ends; its age
  // counts cycles since acceptance (1 = clear pulse, 2 = start pulse, 3+ =
  // waiting for done while counting seconds).
  bit m_running;
  int m_age;
  int m_secs;
  bit m_err;
  bit m_zera;
  bit m_liga;
  bit m_pronto;

  task automatic model_reset();
    m_running = 1'b0;
    m_age     = 0;
    m_secs    = 0;
    m_err     = 1'b0;
    m_zera    = 1'b0;
    m_liga    = 1'b0;
    m_pronto  = 1'b0;
  endtask

  task automatic model_edge(input bit ini, input bit can, input bit fim, input bit to);
    m_zera   = 1'b0;
    m_liga   = 1'b0;
    m_pronto = 1'b0;
    if (!m_running) begin
      if (ini) begin
        m_running = 1'b1;
        m_age     = 1;
        m_secs    = 0;
        m_err     = 1'b0;
        m_zera    = 1'b1;
      end else if (can) begin
        m_err = 1'b0;
      end
    end else if (can) begin
      m_running = 1'b0;
      m_zera    = 1'b1;
    end else if (m_age < 3) begin
      m_age = m_age + 1;
      if (m_age == 2) m_liga = 1'b1;
    end else begin
      if (to) m_secs = (m_secs + 1 > SAT_S) ? SAT_S : m_secs + 1;
      if (fim) begin
        m_running = 1'b0;
        m_pronto  = 1'b1;
      end else if (to && m_secs == MAX_S) begin
        m_running = 1'b0;
        m_err     = 1'b1;
        m_zera    = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Compare every DUT output with the model.
  task automatic compare_model();
    check("segundos", int'(segundos), m_secs);
    check("erro", int'(erro), int'(m_err));
    check("ocupado", int'(ocupado), int'(m_running));
    check("pronto", int'(pronto), int'(m_pronto));
    check("liga", int'(liga_ebulidor), int'(m_liga));
    check("zera", int'(zera_ebulidor), int'(m_zera));
    check("pulses_exclusive",
          int'((int'(liga_ebulidor) + int'(zera_ebulidor) + int'(pronto)) <= 1), 1);
  endtask

  // Drive one cycle of inputs (from a negedge), compare just after the
  // posedge, and return at the following negedge.
  task automatic step(input bit ini, input bit can, input bit fim, input bit to);
    iniciar      = ini;
    cancela      = can;
    fim_ebulidor = fim;
    timeout      = to;
    model_edge(ini, can, fim, to);
    @(posedge clock);
    #1;
    compare_model();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_liga"}, int'(liga_ebulidor), 0);
    check({tag, "_zera"}, int'(zera_ebulidor), 0);
    check({tag, "_ocupado"}, int'(ocupado), 0);
    check({tag, "_pronto"}, int'(pronto), 0);
    check({tag, "_erro"}, int'(erro), 0);
    check({tag, "_segundos"}, int'(segundos), 0);
  endtask

  initial begin
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Success: two ticks then done.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("ok_zera_n1", int'(zera_ebulidor), 1);
    check("ok_liga_n1", int'(liga_ebulidor), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("ok_liga_n2", int'(liga_ebulidor), 1);
    check("ok_zera_n2", int'(zera_ebulidor), 0);
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("ok_pronto", int'(pronto), 1);
    check("ok_segundos", int'(segundos), 2);
    check("ok_erro", int'(erro), 0);
    idle(1);
    check("ok_pronto_one_cycle", int'(pronto), 0);
    check("ok_segundos_frozen", int'(segundos), 2);

    // Failure: four ticks, no done.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < MAX_S; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    check("fail_erro", int'(erro), 1);
    check("fail_segundos", int'(segundos), 4);
    check("fail_zera", int'(zera_ebulidor), 1);
    check("fail_pronto", int'(pronto), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("fail_erro_held", int'(erro), 1);
    check("fail_zera_once", int'(zera_ebulidor), 0);
    check("fail_segundos_frozen", int'(segundos), 4);

    // Done together with the final tick resolves as success.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < MAX_S - 1; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("sim_pronto", int'(pronto), 1);
    check("sim_erro", int'(erro), 0);
    check("sim_segundos", int'(segundos), 4);

    // Cancel with done in the same cycle at segundos=1.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check("can_zera", int'(zera_ebulidor), 1);
    check("can_ocupado", int'(ocupado), 0);
    check("can_pronto", int'(pronto), 0);
    check("can_erro", int'(erro), 0);

    // Stale done held from before the request.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("stale_pronto_zera", int'(pronto), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("stale_pronto_liga", int'(pronto), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("stale_pronto_enter", int'(pronto), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("stale_pronto_espera", int'(pronto), 1);

    // Request while busy is ignored, then reset mid-wait.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("busy_liga_first", int'(liga_ebulidor), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("busy_no_second_liga", int'(liga_ebulidor), 0);
    check("busy_no_zera", int'(zera_ebulidor), 0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("busy_segundos", int'(segundos), 1);
    iniciar = 1'b0;
    timeout = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clock);
    check_all_zero("reset_held");
    reset = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("post_reset_zera", int'(zera_ebulidor), 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
